// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin two-master arbiter sequencing one read/write strobe per grant onto the peripheral bus.
// Define IO_ARB_FIXED_PRIORITY_EN for fixed priority, where port 0 wins every tie.
module io_bus_arbiter #(
  parameter int ID_W   = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ID_W-1:0]   id0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ID_W-1:0]   id1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ID_W-1:0]   bus_id,
  output logic [DATA_W-1:0] bus_din,
  output logic              bus_read,
  output logic              bus_write,
  input  logic [DATA_W-1:0] bus_dout,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic win;
  logic pick;
  logic sel_we;
`ifdef IO_ARB_FIXED_PRIORITY_EN
  assign pick = !req0;
`else
  logic last_grant;
  assign pick = (req0 && req1) ? !last_grant : req1;
`endif
  assign sel_we = pick ? we1 : we0;
  assign busy   = state != IDLE;
  // Bus outputs are loaded at grant so they are stable for the whole ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win       <= 1'b0;
      bus_id    <= '0;
      bus_din   <= '0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
`ifndef IO_ARB_FIXED_PRIORITY_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (req0 || req1) begin
          win       <= pick;
          bus_id    <= pick ? id1 : id0;
          bus_din   <= sel_we ? (pick ? wdata1 : wdata0) : '0;
          bus_read  <= !sel_we;
          bus_write <= sel_we;
          state     <= ACCESS;
`ifndef IO_ARB_FIXED_PRIORITY_EN
          last_grant <= pick;
`endif
        end
        ACCESS: begin
          if (bus_read && win) rdata1 <= bus_dout;
          if (bus_read && !win) rdata0 <= bus_dout;
          ack0      <= !win;
          ack1      <= win;
          bus_id    <= '0;
          bus_din   <= '0;
          bus_read  <= 1'b0;
          bus_write <= 1'b0;
          state     <= DONE;
        end
        default: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
